freq_meter_multi: RTL and testbench
===================================

Name: freq_meter_multi

Overview:
Parametrised multi-channel gated frequency counter that supplies the processor's frequency input port and its data-valid flag. Each channel counts rising edges of an asynchronous input over a common gate window. The gate length is selectable at run time. At the end of each window, all channel counts are latched together. A valid/acknowledge handshake replaces the earlier free-running single-channel level.

Parameters:
CHANNELS, 4, number of measured input signals (1..16)
CNT_WIDTH, 32, width of each edge counter and result register
CLK_HZ, 50000000, clk_clk frequency in Hz; must be a multiple of 1000 and at least 1000
SEL_W, 4, width of rd_ch; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
sig_in  in  CHANNELS  asynchronous measured signals, one bit per channel
meas_en  in  1  1 = measuring; 0 = counters held cleared
gate_sel  in  2  gate length: 0 = CLK_HZ cycles (1 s), 1 = CLK_HZ/10, 2 = CLK_HZ/100, 3 = CLK_HZ/1000
rd_ch  in  SEL_W  channel select for the read port
freq_ack  in  1  one-cycle pulse; consumes the current result set
freq_data  out  CNT_WIDTH  latched count of channel rd_ch
freq_ovf  out  1  saturation flag of channel rd_ch
freq_en  out  1  new result set available and not yet acknowledged
freq_overrun  out  1  a result set was replaced before it was acknowledged

Behaviour:
- Reset:
  - Synchronous; reset has priority over all other events.
  - All outputs are 0; synchronisers, edge counters, gate counter and result registers are cleared.
  - gate length is loaded from gate_sel on the first cycle after reset is released.
- Input path:
  - Each sig_in bit passes through a 2-FF synchroniser followed by a delay register.
  - Edge = sync2 & ~sync3.
  - Latency from the input rising edge to the counter increment is 3 cycles.
  - Input pulses shorter than 2 clk_clk periods are not guaranteed to be counted.
- Gate counter:
  - Runs from 0 to G-1, where G is the gate length sampled at window start.
  - A gate_sel change mid-window takes effect from the next window.
- Terminal cycle (gate_cnt == G-1):
  - Result = edge counter plus that cycle's edge, saturated.
  - Results and ovf flags for all channels are latched simultaneously.
  - Edge counters reset to 0; gate_cnt reset to 0; new G sampled.
  - Every edge is counted in exactly one window.
- Saturation:
  - An edge counter holds at all-ones once reached.
  - That channel's ovf bit is set for the window and latched alongside its result.
- meas_en = 0:
  - Gate and edge counters are held at 0; result registers and flags are retained.
  - On meas_en rising, a full fresh window starts.
- Read port:
  - Registered. freq_data and freq_ovf reflect rd_ch one cycle after rd_ch changes.
  - They also update one cycle after a latch.
  - rd_ch >= CHANNELS reads 0.
- Handshake:
  - Latch sets freq_en = 1 in the following cycle.
  - freq_ack clears freq_en and freq_overrun.
  - Latch while freq_en = 1 with no ack in that cycle sets freq_overrun = 1.
  - Latch and ack in the same cycle: freq_en stays 1, freq_overrun is 0 (new data wins).
  - freq_ack while freq_en = 0 has no effect.
- Reset mid-window: the partial window is discarded; after release the first window is full length.

Test Plan:
Use CLK_HZ=10000, CHANNELS=4, CNT_WIDTH=32 unless stated; gate lengths are then 10000/1000/100/10 cycles.
- Reset: hold reset_reset 5 cycles with sig_in toggling -> all outputs 0, no freq_en for the following 99 cycles with gate_sel=2.
- Counting: gate_sel=2; ch0 period 10 clocks, ch1 period 4, ch2 static, ch3 period 100 -> from the second window onward, reading rd_ch 0..3 gives 10, 25, 0, 1; freq_ovf = 0.
- Saturation: CNT_WIDTH=8, gate_sel=0, ch2 period 2 -> freq_data=255 and freq_ovf=1 on rd_ch=2; ch0 period 50 -> 200 with ovf 0.
- Handshake: no ack across two latches -> freq_overrun=1 and freq_en=1; ack pulse -> both 0 next cycle; ack coincident with a latch -> freq_en stays 1, overrun 0.
- Gate change: switch gate_sel 2 -> 3 at gate_cnt=40 -> the current window latches 100 cycles after its start, the next one 10 cycles later; ch0 period 10 reads 10 then 1.
- Enable and mid-run reset: meas_en low for 500 cycles -> no new latch; re-enable -> first latch exactly G cycles later. Reset at gate_cnt=50 -> next latch G cycles after release.

Source files
------------

// File: rtl/freq_meter_multi_if.sv
// freq_meter_multi_if: read-port / handshake bundle between the frequency meter and its consumer
interface freq_meter_multi_if #(
    parameter int CNT_WIDTH = 32,
    parameter int SEL_W     = 4
);
    logic [SEL_W-1:0]     rd_ch;
    logic                 freq_ack;
    logic [CNT_WIDTH-1:0] freq_data;
    logic                 freq_ovf;
    logic                 freq_en;
    logic                 freq_overrun;
    modport master (output rd_ch, freq_ack, input freq_data, freq_ovf, freq_en, freq_overrun);
    modport slave  (input rd_ch, freq_ack, output freq_data, freq_ovf, freq_en, freq_overrun);
endinterface

// File: rtl/freq_meter_multi.sv
// freq_meter_multi: multi-channel gated edge counter with simultaneous latch and valid/ack read port
module freq_meter_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int CLK_HZ    = 50000000,
    parameter int SEL_W     = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic                meas_en,
    input  logic [1:0]          gate_sel,
    freq_meter_multi_if.slave   bus
);
    localparam int GW   = $clog2(CLK_HZ + 1);
    localparam int NSEL = 2 ** SEL_W;

    logic [CHANNELS-1:0]  sync1, sync2, sync3, edges;
    logic [GW-1:0]        gate_len, gate_cnt, sel_len, cur_len;
    logic                 run, last;
    logic [CNT_WIDTH-1:0] cnt     [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_nxt [CHANNELS];
    logic [CNT_WIDTH-1:0] res     [CHANNELS];
    logic [CNT_WIDTH-1:0] res_nxt [CHANNELS];
    logic [CHANNELS-1:0]  ovf, ovf_nxt;
    logic [CNT_WIDTH-1:0] rd_data [NSEL];
    logic [NSEL-1:0]      rd_ovf;

    // gate length decode; a stopped gate uses the live selection so a fresh window starts at once
    always_comb begin
        sel_len = gate_sel == 2'd0 ? GW'(CLK_HZ) :
                  gate_sel == 2'd1 ? GW'(CLK_HZ / 10) :
                  gate_sel == 2'd2 ? GW'(CLK_HZ / 100) : GW'(CLK_HZ / 1000);
        cur_len = run ? gate_len : sel_len;
        last    = meas_en && (gate_cnt == cur_len - GW'(1));
        edges   = sync2 & ~sync3;
    end

    // per-channel saturating next count and the values that will be latched at the window end
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = &cnt[i] ? cnt[i] : cnt[i] + CNT_WIDTH'(edges[i]);
            res_nxt[i] = last ? cnt_nxt[i] : res[i];
            ovf_nxt[i] = last ? &cnt_nxt[i] : ovf[i];
        end
    end

    // read mux padded to the full select range so unused selects return zero
    always_comb begin
        rd_data = '{default: '0};
        rd_ovf  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_data[i] = res_nxt[i];
            rd_ovf[i]  = ovf_nxt[i];
        end
    end

    // two-flop synchroniser plus delay stage for edge detection
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // gate counter; length captured at each window start and held for the whole window
    always_ff @(posedge clk_clk) begin
        if (reset_reset || !meas_en) begin
            gate_cnt <= '0;
            run      <= 1'b0;
            if (reset_reset)
                gate_len <= '0;
        end else begin
            gate_cnt <= last ? '0 : gate_cnt + GW'(1);
            run      <= 1'b1;
            if (last || !run)
                gate_len <= sel_len;
        end
    end

    // edge counters restart every window; results and ovf flags latch together at the terminal cycle
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
                res[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= (!meas_en || last) ? '0 : cnt_nxt[i];
                res[i] <= res_nxt[i];
            end
            ovf <= ovf_nxt;
        end
    end

    // registered read port and valid/overrun handshake; a latch coinciding with ack keeps new data valid
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bus.freq_data    <= '0;
            bus.freq_ovf     <= 1'b0;
            bus.freq_en      <= 1'b0;
            bus.freq_overrun <= 1'b0;
        end else begin
            bus.freq_data    <= rd_data[bus.rd_ch];
            bus.freq_ovf     <= rd_ovf[bus.rd_ch];
            bus.freq_en      <= last | (bus.freq_en & ~bus.freq_ack);
            bus.freq_overrun <= ~bus.freq_ack & (bus.freq_overrun | (last & bus.freq_en));
        end
    end
endmodule

// File: tb/tb_freq_meter_multi.sv
// tb_freq_meter_multi: directed and randomised checks of the frequency meter against a window-level model
module tb_freq_meter_multi;
    localparam int CH = 4;
    localparam int HZ = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, meas_en, ack;
    logic [1:0]    gate_sel;
    logic [3:0]    rd_ch;
    logic [CH-1:0] sig_in;

    freq_meter_multi_if #(.CNT_WIDTH(32), .SEL_W(4)) bus32 ();
    freq_meter_multi_if #(.CNT_WIDTH(8),  .SEL_W(4)) bus8 ();
    assign bus32.rd_ch    = rd_ch;
    assign bus32.freq_ack = ack;
    assign bus8.rd_ch     = rd_ch;
    assign bus8.freq_ack  = ack;

    freq_meter_multi #(.CHANNELS(CH), .CNT_WIDTH(32), .CLK_HZ(HZ), .SEL_W(4)) dut32 (
        .clk_clk(clk), .reset_reset(rst), .sig_in(sig_in), .meas_en(meas_en),
        .gate_sel(gate_sel), .bus(bus32));
    freq_meter_multi #(.CHANNELS(CH), .CNT_WIDTH(8), .CLK_HZ(HZ), .SEL_W(4)) dut8 (
        .clk_clk(clk), .reset_reset(rst), .sig_in(sig_in), .meas_en(meas_en),
        .gate_sel(gate_sel), .bus(bus8));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int period [CH];
    int phase  [CH];
    bit rand_rd = 0;

    // reference model: input rises counted two cycles later, window boundaries as absolute cycle numbers
    logic [CH-1:0] m_prev = '0, m_q0 = '0, m_q1 = '0;
    bit     m_active = 0, m_en = 0, m_ovr = 0, m_latched = 0;
    int     m_end = 0;
    longint m_acc [CH];
    longint m_res [CH];
    longint m_rdraw = 0;

    function automatic int glen(input logic [1:0] s);
        return s == 2'd0 ? HZ : s == 2'd1 ? HZ / 10 : s == 2'd2 ? HZ / 100 : HZ / 1000;
    endfunction

    function automatic logic [63:0] rd_exp(input int w);
        logic [63:0] mx, v;
        mx = (64'd1 << w) - 64'd1;
        v  = 64'(m_rdraw);
        return ((v >= mx ? 64'd1 : 64'd0) << w) | (v > mx ? mx : v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    task automatic model_cycle();
        logic [CH-1:0] lvl, cur;
        lvl    = rst ? '0 : sig_in;
        cur    = m_q1;
        m_q1   = m_q0;
        m_q0   = lvl & ~m_prev;
        m_prev = lvl;
        m_latched = 0;
        if (rst) begin
            m_q0 = '0; m_q1 = '0;
            m_active = 0; m_en = 0; m_ovr = 0; m_rdraw = 0;
            for (int i = 0; i < CH; i++) begin m_acc[i] = 0; m_res[i] = 0; end
        end else begin
            if (meas_en) begin
                if (!m_active) begin
                    m_active = 1;
                    m_end = cyc + glen(gate_sel) - 1;
                end
                for (int i = 0; i < CH; i++) m_acc[i] += longint'(cur[i]);
                if (cyc == m_end) begin
                    for (int i = 0; i < CH; i++) begin m_res[i] = m_acc[i]; m_acc[i] = 0; end
                    m_latched = 1;
                    m_end = cyc + glen(gate_sel);
                end
            end else begin
                m_active = 0;
                for (int i = 0; i < CH; i++) m_acc[i] = 0;
            end
            m_ovr = !ack && (m_ovr || (m_latched && m_en));
            m_en  = m_latched || (m_en && !ack);
            m_rdraw = int'(rd_ch) < CH ? m_res[int'(rd_ch)] : 0;
        end
    endtask

    task automatic gen_sig();
        for (int i = 0; i < CH; i++)
            sig_in[i] = period[i] == 0 ? 1'b0 : ((cyc + phase[i]) % period[i]) < period[i] / 2;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        gen_sig();
        chk("handshake", {bus32.freq_en, bus32.freq_overrun, bus8.freq_en, bus8.freq_overrun},
            {m_en, m_ovr, m_en, m_ovr});
        chk("read32", {bus32.freq_ovf, bus32.freq_data}, rd_exp(32));
        chk("read8", {bus8.freq_ovf, bus8.freq_data}, rd_exp(8));
        if (rand_rd) rd_ch = 4'($urandom_range(0, 7));
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic wait_latch(input int budget);
        int n;
        n = 0;
        do begin step(); n++; end while (!m_latched && n < budget);
        chk("latch_en", bus32.freq_en, 1);
    endtask

    task automatic wait_en(input int budget, output int n);
        n = 0;
        do begin step(); n++; end while (bus32.freq_en !== 1'b1 && n < budget);
    endtask

    task automatic rand_periods();
        for (int i = 0; i < CH; i++) begin
            period[i] = $urandom_range(2, 30);
            phase[i]  = $urandom_range(0, 99);
        end
    endtask

    initial begin
        int n, s, t;
        int exp_cnt [CH];
        rst = 1'b1; meas_en = 1'b1; ack = 1'b0; gate_sel = 2'd2; rd_ch = '0;
        rand_periods();
        gen_sig();

        // reset held with toggling inputs, then no valid for 99 cycles
        repeat (5) begin
            step();
            chk("reset_zero", {bus32.freq_en, bus32.freq_overrun, bus32.freq_ovf, bus32.freq_data}, 0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 99; k++) begin
            step();
            chk("no_early_en", bus32.freq_en, 0);
        end
        step();
        chk("first_latch", bus32.freq_en, 1);

        // counting with fixed periods; the second full window is checked per channel
        period = '{10, 4, 0, 100};
        for (int i = 0; i < CH; i++) phase[i] = $urandom_range(0, 99);
        exp_cnt = '{10, 25, 0, 1};
        pulse_ack();
        wait_latch(150);
        wait_latch(150);
        for (int i = 0; i < CH; i++) begin
            rd_ch = 4'(i);
            step();
            chk("count_ch", {bus32.freq_ovf, bus32.freq_data}, 64'(exp_cnt[i]));
        end
        rd_ch = 4'd5;
        step();
        chk("rd_out_of_range", {bus32.freq_ovf, bus32.freq_data}, 0);

        // 1 s gate: 8-bit instance saturates on the fast channel only
        gate_sel = 2'd0;
        period = '{50, 7, 2, 0};
        rand_rd = 1;
        wait_latch(150);
        wait_latch(HZ + 50);
        rand_rd = 0;
        rd_ch = 4'd2;
        step();
        chk("sat8_ch2", {bus8.freq_ovf, bus8.freq_data}, {55'd0, 1'b1, 8'd255});
        chk("wide_ch2", {bus32.freq_ovf, bus32.freq_data}, 64'd5000);
        rd_ch = 4'd0;
        step();
        chk("sat8_ch0", {bus8.freq_ovf, bus8.freq_data}, 64'd200);

        // handshake: overrun after two unacked latches, ack clears, ack on a latch keeps valid
        gate_sel = 2'd2;
        meas_en = 1'b0;
        pulse_ack();
        meas_en = 1'b1;
        rand_periods();
        rand_rd = 1;
        wait_latch(150);
        wait_latch(150);
        chk("overrun_set", {bus32.freq_en, bus32.freq_overrun}, 2'b11);
        pulse_ack();
        chk("ack_clears", {bus32.freq_en, bus32.freq_overrun}, 2'b00);
        pulse_ack();
        chk("ack_idle", {bus32.freq_en, bus32.freq_overrun}, 2'b00);
        wait_latch(150);
        wait_latch(150);
        n = 0;
        while (cyc != m_end && n < 200) begin step(); n++; end
        pulse_ack();
        chk("ack_on_latch", {bus32.freq_en, bus32.freq_overrun}, 2'b10);

        // gate change mid-window takes effect from the next window
        rand_rd = 0;
        rd_ch = '0;
        period[0] = 10;
        meas_en = 1'b0;
        ack = 1'b1;
        repeat (5) step();
        ack = 1'b0;
        meas_en = 1'b1;
        s = cyc;
        n = 0;
        do begin
            step();
            n++;
            if (cyc == s + 40) gate_sel = 2'd3;
        end while (bus32.freq_en !== 1'b1 && n < 300);
        chk("gate_len_old", n, 100);
        chk("gate_ch0_old", bus32.freq_data, 10);
        t = cyc;
        pulse_ack();
        wait_en(100, n);
        chk("gate_len_new", cyc - t, 10);
        chk("gate_ch0_new", bus32.freq_data, 1);

        // measurement disabled: no latch; re-enable starts a full window
        gate_sel = 2'd2;
        ack = 1'b1;
        meas_en = 1'b0;
        step();
        ack = 1'b0;
        repeat (500) step();
        chk("disabled_no_en", bus32.freq_en, 0);
        meas_en = 1'b1;
        wait_en(300, n);
        chk("reenable_len", n, 100);

        // reset at gate_cnt 50 discards the partial window
        t = cyc;
        pulse_ack();
        while (cyc < t + 50) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_data_zero", bus32.freq_data, 0);
        wait_en(300, n);
        chk("reset_restart_len", n, 100);

        // randomised traffic: random periods, reads, acks, gate changes, enable drops and resets
        rand_rd = 1;
        for (int k = 0; k < 4000; k++) begin
            if (k % 400 == 0) rand_periods();
            ack = ($urandom_range(0, 5) == 0);
            meas_en = ($urandom_range(0, 299) != 0);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) gate_sel = 2'($urandom_range(2, 3));
            step();
        end
        rst = 1'b0;
        ack = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
